// File: rtl/bram11_arbiter_pkg.sv
// Shared constants, owner encoding and address helpers for the 11-word BRAM arbiter.
package bram11_arbiter_pkg;

  localparam int DEPTH = 11;
  localparam int AW    = 12;
  localparam int DW    = 32;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ENG  = 1'b1
  } owner_e;

  // Byte lanes [1:0] never select a word.
  function automatic logic [AW-3:0] word_idx(input logic [AW-1:0] addr);
    return addr[AW-1:2];
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return word_idx(addr) < (AW-2)'(DEPTH);
  endfunction

endpackage

// File: rtl/bram11_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; lock only breaks ties in favour of the engine.
module bram11_arbiter_rr_arb2
  import bram11_arbiter_pkg::*;
(
  input  logic   req_h,
  input  logic   req_e,
  input  logic   lock,
  input  owner_e last_owner,
  output logic   gnt_h,
  output logic   gnt_e,
  output owner_e last_owner_nxt
);

  always_comb begin
    gnt_h          = 1'b0;
    gnt_e          = 1'b0;
    last_owner_nxt = last_owner;
    if (req_h && req_e) begin
      // Previous contention winner yields, unless the engine holds a lock.
      if (lock || last_owner == OWN_HOST) begin
        gnt_e          = 1'b1;
        last_owner_nxt = OWN_ENG;
      end else begin
        gnt_h          = 1'b1;
        last_owner_nxt = OWN_HOST;
      end
    end else begin
      gnt_h = req_h;
      gnt_e = req_e;
    end
  end

endmodule

// File: rtl/bram11_arbiter.sv
// Host/engine access controller for a single-port 11-word BRAM: arbitration,
// range rejection, and the one-cycle read return with EN0 held for valid Do0.
module bram11_arbiter
  import bram11_arbiter_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          h_req,
  input  logic [3:0]    h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          h_err,
  input  logic          e_req,
  input  logic [3:0]    e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  input  logic          e_lock,
  output logic          e_gnt,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  output logic          e_err,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  input  logic [DW-1:0] bram_do
);

  logic          arb_h, arb_e, gnt, win_ok;
  owner_e        lo_nxt, win_owner;
  logic [3:0]    win_we;
  logic [AW-1:0] win_addr;

  logic          locked_q, locked_d;
  owner_e        last_owner_q, last_owner_d;
  logic          rd_pend_q, rd_pend_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic          rd_oor_q, rd_oor_d;
  logic          wr_err_q, wr_err_d;
  owner_e        wr_owner_q, wr_owner_d;
  logic [AW-1:0] addr_q, addr_d;

  bram11_arbiter_rr_arb2 u_arb (
    .req_h          (h_req),
    .req_e          (e_req),
    .lock           (locked_q),
    .last_owner     (last_owner_q),
    .gnt_h          (arb_h),
    .gnt_e          (arb_e),
    .last_owner_nxt (lo_nxt)
  );

  always_comb begin
    h_gnt     = arb_h & ~RST;
    e_gnt     = arb_e & ~RST;
    gnt       = h_gnt | e_gnt;
    win_owner = e_gnt ? OWN_ENG : OWN_HOST;
    win_we    = e_gnt ? e_we    : h_we;
    win_addr  = e_gnt ? e_addr  : h_addr;
    bram_di   = e_gnt ? e_wdata : h_wdata;
    win_ok    = in_range(win_addr);

    // EN stays up through the return cycle so Do0 is not gated off.
    bram_en   = ~RST & ((gnt & win_ok) | (rd_pend_q & ~rd_oor_q));
    bram_we   = (gnt & win_ok) ? win_we : 4'h0;
    bram_addr = gnt ? win_addr : addr_q;
    addr_d    = bram_addr;

    locked_d     = e_lock & (locked_q | e_gnt);
    last_owner_d = (h_gnt | e_gnt) && h_req && e_req ? lo_nxt : last_owner_q;
    rd_pend_d    = gnt & (win_we == 4'h0);
    rd_owner_d   = win_owner;
    rd_oor_d     = ~win_ok;
    wr_err_d     = gnt & (win_we != 4'h0) & ~win_ok;
    wr_owner_d   = win_owner;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      locked_q     <= 1'b0;
      last_owner_q <= OWN_ENG;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_HOST;
      rd_oor_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_owner_q   <= OWN_HOST;
      addr_q       <= '0;
    end else begin
      locked_q     <= locked_d;
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      wr_err_q     <= wr_err_d;
      wr_owner_q   <= wr_owner_d;
      addr_q       <= addr_d;
    end
  end

  // Returns are masked while RST is high so an in-flight read is dropped.
  always_comb begin
    h_rvalid = ~RST & rd_pend_q & (rd_owner_q == OWN_HOST);
    e_rvalid = ~RST & rd_pend_q & (rd_owner_q == OWN_ENG);
    h_rdata  = (h_rvalid & ~rd_oor_q) ? bram_do : '0;
    e_rdata  = (e_rvalid & ~rd_oor_q) ? bram_do : '0;
    h_err    = (h_rvalid & rd_oor_q) | (~RST & wr_err_q & (wr_owner_q == OWN_HOST));
    e_err    = (e_rvalid & rd_oor_q) | (~RST & wr_err_q & (wr_owner_q == OWN_ENG));
  end

endmodule

// File: tb/tb_bram11_arbiter.sv
// Scoreboard bench for bram11_arbiter with a behavioural single-port BRAM model.
module tb_bram11_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        h_req = 1'b0, e_req = 1'b0, e_lock = 1'b0;
  logic [3:0]  h_we = 4'h0, e_we = 4'h0;
  logic [11:0] h_addr = '0, e_addr = '0;
  logic [31:0] h_wdata = '0, e_wdata = '0;
  logic        h_gnt, h_rvalid, h_err, e_gnt, e_rvalid, e_err;
  logic [31:0] h_rdata, e_rdata;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [11:0] bram_addr;
  logic [31:0] bram_di, bram_do;

  bram11_arbiter dut (
    .CLK(CLK), .RST(RST),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_lock(e_lock),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata), .e_err(e_err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do)
  );

  always #5 CLK = ~CLK;

  // BRAM: address registered when enabled, Do0 = EN0 & word[registered addr].
  logic [31:0] mem [0:10] = '{default: 32'h0};
  int          areg = 0;
  always @(posedge CLK) begin
    if (bram_en) begin
      if (int'(bram_addr[11:2]) < 11) begin
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) mem[int'(bram_addr[11:2])][8*b +: 8] <= bram_di[8*b +: 8];
      end
      areg <= int'(bram_addr[11:2]);
    end
  end
  assign bram_do = (bram_en && areg < 11) ? mem[areg] : 32'h0;

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] d;
    logic        err;
  } exp_t;

  exp_t        hq[$], eq[$];
  logic [31:0] shadow [0:10] = '{default: 32'h0};
  logic [31:0] last_h_rdata = '0, last_e_rdata = '0;
  logic [1:0]  glog [0:255];
  logic        enlog [0:255];
  int          cyc = 0;

  // Expected outcome of a granted access; in-range writes update the shadow and expect nothing.
  task automatic sb(input logic [3:0] we, input logic [11:0] a, input logic [31:0] wd,
                    output bit push, output exp_t x);
    int  idx;
    bit  oor;
    idx   = int'(a[11:2]);
    oor   = idx >= 11;
    x.rd  = (we == 4'h0);
    x.d   = 32'h0;
    x.err = oor;
    push  = 1'b1;
    if (we == 4'h0) begin
      if (!oor) x.d = shadow[idx];
    end else if (!oor) begin
      push = 1'b0;
      for (int b = 0; b < 4; b++) if (we[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  always @(negedge CLK) begin
    exp_t x;
    bit   p;
    glog[cyc % 256]  = {e_gnt, h_gnt};
    enlog[cyc % 256] = bram_en;
    cyc++;
    if (RST) begin
      chk("rst_gnt", 64'({h_gnt, e_gnt}), 64'd0);
      chk("rst_en", 64'(bram_en), 64'd0);
      chk("rst_ret", 64'({h_rvalid, e_rvalid, h_err, e_err}), 64'd0);
      hq.delete();
      eq.delete();
    end else begin
      chk("one_gnt", 64'(h_gnt & e_gnt), 64'd0);
      if (hq.size() > 0) begin
        x = hq.pop_front();
        chk("h_rvalid", 64'(h_rvalid), 64'(x.rd));
        chk("h_rdata", 64'(h_rdata), 64'(x.d));
        chk("h_err", 64'(h_err), 64'(x.err));
      end else if (h_rvalid || h_err || h_rdata != 0)
        chk("h_unexp", 64'({h_rvalid, h_err, h_rdata}), 64'd0);
      if (eq.size() > 0) begin
        x = eq.pop_front();
        chk("e_rvalid", 64'(e_rvalid), 64'(x.rd));
        chk("e_rdata", 64'(e_rdata), 64'(x.d));
        chk("e_err", 64'(e_err), 64'(x.err));
      end else if (e_rvalid || e_err || e_rdata != 0)
        chk("e_unexp", 64'({e_rvalid, e_err, e_rdata}), 64'd0);
      if (h_rvalid) last_h_rdata = h_rdata;
      if (e_rvalid) last_e_rdata = e_rdata;
      if (h_gnt) begin sb(h_we, h_addr, h_wdata, p, x); if (p) hq.push_back(x); end
      if (e_gnt) begin sb(e_we, e_addr, e_wdata, p, x); if (p) eq.push_back(x); end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Single uncontended access; expects the grant in the request cycle.
  task automatic op(input bit eng, input logic [3:0] we, input logic [11:0] a,
                    input logic [31:0] wd, output logic en_at_gnt);
    int n;
    if (eng) begin e_req = 1'b1; e_we = we; e_addr = a; e_wdata = wd; end
    else     begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; end
    n = 0;
    do begin @(negedge CLK); n++; end while (!(eng ? e_gnt : h_gnt) && n < 50);
    en_at_gnt = bram_en;
    chk(eng ? "e_gnt_lat" : "h_gnt_lat", 64'(n), 64'd1);
    @(posedge CLK); #1;
    h_req = 1'b0; e_req = 1'b0; h_we = 4'h0; e_we = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en;
    int   st;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst", 64'({h_rvalid, e_rvalid, h_err, e_err}), 64'd0);
    @(posedge CLK); #1;

    // Full write then readback, partial byte write then engine readback.
    op(0, 4'hF, 12'h008, 32'h11223344, en);
    op(0, 4'h0, 12'h008, 32'h0, en);
    idle(1);
    chk("h_readback", 64'(last_h_rdata), 64'h11223344);
    op(0, 4'h2, 12'h008, 32'hAABBCCDD, en);
    op(1, 4'h0, 12'h008, 32'h0, en);
    idle(1);
    chk("e_byte_we", 64'(last_e_rdata), 64'h1122CC44);
    op(0, 4'hF, 12'h000, 32'hA0A0_0000, en);
    op(1, 4'hF, 12'h004, 32'hB1B1_0001, en);
    idle(2);

    // Contended back-to-back reads alternate, first tie to host.
    st = cyc;
    h_req = 1'b1; h_we = 4'h0; h_addr = 12'h000;
    e_req = 1'b1; e_we = 4'h0; e_addr = 12'h004;
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1;
    h_req = 1'b0; e_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("alt_gnt", 64'(glog[(st + i) % 256]), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("alt_en", 64'(enlog[(st + i) % 256]), 64'd1);
    end
    idle(2);

    // Lock: engine keeps every tie until a cycle after e_lock drops.
    e_req = 1'b1; e_lock = 1'b1; e_addr = 12'h010;
    @(negedge CLK); chk("lock_first", 64'(e_gnt), 64'd1);
    @(posedge CLK); #1; h_req = 1'b1; h_addr = 12'h000;
    repeat (4) begin @(negedge CLK); chk("lock_hold", 64'({h_gnt, e_gnt}), 64'd1); end
    @(posedge CLK); #1; e_lock = 1'b0;
    @(negedge CLK); chk("lock_tail", 64'({h_gnt, e_gnt}), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK); chk("lock_release", 64'({h_gnt, e_gnt}), 64'd2);
    @(posedge CLK); #1; h_req = 1'b0; e_req = 1'b0;
    idle(1);
    e_req = 1'b1; e_lock = 1'b1; e_addr = 12'h00C;
    @(negedge CLK);
    @(posedge CLK); #1; e_req = 1'b0; h_req = 1'b1; h_addr = 12'h004;
    @(negedge CLK); chk("lock_idle_host", 64'({h_gnt, e_gnt}), 64'd2);
    @(posedge CLK); #1; h_req = 1'b0; e_lock = 1'b0;
    idle(2);

    // Out-of-range accesses: no EN, error return, RAM untouched.
    op(0, 4'h0, 12'h02C, 32'h0, en);
    chk("oor_rd_en", 64'(en), 64'd0);
    idle(2);
    op(0, 4'hF, 12'h030, 32'hDEADBEEF, en);
    chk("oor_wr_en", 64'(en), 64'd0);
    op(1, 4'h0, 12'hFFC, 32'h0, en);
    idle(2);
    for (int i = 0; i < 11; i++) chk("mem_keep", 64'(mem[i]), 64'(shadow[i]));
    op(0, 4'h0, 12'h028, 32'h0, en);
    idle(2);

    // Reset during the return cycle drops the read; first tie then goes to host.
    op(1, 4'h0, 12'h008, 32'h0, en);
    RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    idle(3);
    h_req = 1'b1; h_addr = 12'h000; e_req = 1'b1; e_addr = 12'h004;
    @(negedge CLK); chk("rst_tie", 64'({h_gnt, e_gnt}), 64'd2);
    @(posedge CLK); #1; h_req = 1'b0; e_req = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
